// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access unit.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 2;
    // Wide enough for the largest legal load value (WAIT_CYCLES-1 = 14).
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter timing a memory access; zero flags the final wait cycle.
module mem_wait_counter
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic zero
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// LC-3 style MAR/MDR memory interface: one read or write per request,
// fixed-length wait, then a one-cycle completion pulse.
module mem_access_unit
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic [15:0] Data_from_dataBus,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] Data_from_mem,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] Data_to_mem,
    output logic        Mem_CE,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic        busy,
    output logic        mem_done
);

    state_t state, next_state;
    logic   idle, start, waiting, cnt_zero;

    assign idle    = (state == IDLE);
    assign start   = idle && (req_rd || req_wr);
    assign waiting = (state == RD_WAIT) || (state == WR_WAIT);

    mem_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (Clk),
        .rst    (Reset_ah),
        .load   (start),
        .enable (waiting),
        .zero   (cnt_zero)
    );

    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_rd) begin
                    next_state = RD_WAIT;
                end else if (req_wr) begin
                    next_state = WR_WAIT;
                end
            end
            RD_WAIT: if (cnt_zero) next_state = DONE;
            WR_WAIT: if (cnt_zero) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus loads only land in IDLE, so the address and data hold for the whole access.
    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            MAR <= 16'h0000;
        end else if (idle && LD_MAR) begin
            MAR <= Data_from_dataBus;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            MDR <= 16'h0000;
        end else if (idle && LD_MDR) begin
            MDR <= Data_from_dataBus;
        end else if ((state == RD_WAIT) && cnt_zero) begin
            MDR <= Data_from_mem;
        end
    end

    assign Data_to_mem = MDR;

    always_comb begin
        Mem_CE   = 1'b1;
        Mem_OE   = 1'b1;
        Mem_WE   = 1'b1;
        busy     = (state != IDLE);
        mem_done = (state == DONE);
        case (state)
            RD_WAIT: begin
                Mem_CE = 1'b0;
                Mem_OE = 1'b0;
            end
            WR_WAIT: begin
                Mem_CE = 1'b0;
                Mem_WE = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, memory access duration in cycles (legal range 1..15).
REQ-002 Clk  input  1  sole clock; all state changes on posedge Clk.
REQ-003 Reset_ah  input  1  reset, synchronous, active-high.
REQ-004 LD_MAR  input  1  load MAR from Data_from_dataBus.
REQ-005 LD_MDR  input  1  load MDR from Data_from_dataBus.
REQ-006 Data_from_dataBus  input  16  CPU bus value; carries the effective address from the address adder and store data.
REQ-007 req_rd  input  1  start a memory read at MAR.
REQ-008 req_wr  input  1  start a memory write of MDR to MAR.
REQ-009 Data_from_mem  input  16  memory read data.
REQ-010 MAR  output  16  memory address register, drives the memory address.
REQ-011 MDR  output  16  memory data register, also drives Data_to_mem.
REQ-012 Data_to_mem  output  16  write data, always equal to MDR.
REQ-013 Mem_CE, Mem_OE, Mem_WE  output  1 each  active-low memory strobes.
REQ-014 busy  output  1  high while the state is not IDLE.
REQ-015 mem_done  output  1  one-cycle pulse when an access completes.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RD_WAIT, WR_WAIT and DONE.
REQ-017 IDLE: req_rd=1 SHALL go to RD_WAIT; otherwise req_wr=1 SHALL go to WR_WAIT (read wins when both are high); otherwise the FSM SHALL stay in IDLE.
REQ-018 On entry to RD_WAIT or WR_WAIT, the wait counter SHALL load WAIT_CYCLES-1 and decrement by one each cycle.
REQ-019 The FSM SHALL leave RD_WAIT or WR_WAIT for DONE in the cycle the counter is 0, so each wait state lasts exactly WAIT_CYCLES cycles.
REQ-020 In RD_WAIT: Mem_CE=0, Mem_OE=0, Mem_WE=1.
REQ-021 In WR_WAIT: Mem_CE=0, Mem_OE=1, Mem_WE=0.
REQ-022 In IDLE and DONE, all three strobes SHALL be 1.
REQ-023 Read: MDR SHALL capture Data_from_mem at the clock edge that leaves RD_WAIT, i.e. MDR is valid in DONE.
REQ-024 DONE SHALL last one cycle, SHALL assert mem_done=1, and SHALL always return to IDLE.
REQ-025 Latency from the req edge to mem_done=1 SHALL be WAIT_CYCLES+1 cycles.
REQ-026 LD_MAR and LD_MDR SHALL take effect only in IDLE; they SHALL be ignored while busy=1, so MAR and MDR are stable for the whole access.
REQ-027 In IDLE, LD_MAR and LD_MDR in the same cycle as req_rd or req_wr SHALL load first, and the access SHALL use the newly loaded value.
REQ-028 req_rd and req_wr asserted while busy=1 SHALL be ignored and not queued.
REQ-029 Address and data arithmetic: none; MAR and MDR are plain 16-bit registers with no wrap or extension logic.

Reset
REQ-030 While Reset_ah=1 at a clock edge, the block SHALL set: state=IDLE, MAR=16'h0000, MDR=16'h0000, counter=0, busy=0, mem_done=0, Mem_CE=Mem_OE=Mem_WE=1.
REQ-031 Reset SHALL take priority over LD_MAR, LD_MDR, req_rd and req_wr in the same cycle.
REQ-032 Reset during an access SHALL abort it: no MDR update and no mem_done pulse; strobes are deasserted from the cycle after the reset edge.

Structure
REQ-033 Package lc3_mem_pkg SHALL hold the state enum (IDLE, RD_WAIT, WR_WAIT, DONE) and the default WAIT_CYCLES constant.
REQ-034 The down-counter SHALL be a separate sub-module, mem_wait_counter (parameter WAIT_CYCLES; ports: load, enable, zero), instantiated once.
REQ-035 Strobes, busy and mem_done SHALL be decoded from the state register only.

Verification
REQ-036 Reset: Reset_ah=1 for 2 cycles with garbage inputs -> MAR=0, MDR=0, strobes=1, busy=0, mem_done=0.
REQ-037 Read: LD_MAR with bus=16'h3005, then req_rd, mem returns 16'hBEEF -> Mem_OE=0 for exactly 2 cycles, mem_done on cycle 3, MDR=16'hBEEF.
REQ-038 Write: load MAR=16'h4000 and MDR=16'h1234, then req_wr -> Mem_WE=0 for 2 cycles with Data_to_mem=16'h1234, then mem_done.
REQ-039 Simultaneous and busy requests: req_rd=req_wr=1 in IDLE -> read only; req_wr plus LD_MAR (bus=16'hFFFF) during RD_WAIT -> ignored, MAR unchanged.
REQ-040 Reset mid-read: Reset_ah=1 in the first RD_WAIT cycle -> IDLE next, MDR=0, no mem_done.
REQ-041 WAIT_CYCLES=1 build: a read completes with mem_done on cycle 2 and Mem_OE low for 1 cycle.
